// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the fetch path.
// Holds the address/nibble widths, FSM state encodings and program byte field positions.
package program_loader_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_NIB_W  = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HI    = 3'd1;
  localparam logic [2:0] ST_LO    = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Program byte layout: instruction in the upper nibble, operand in the lower.
  localparam int INSTR_LSB = 4;
  localparam int OPER_LSB  = 0;

endpackage

// File: rtl/program_loader_counter.sv
// Loadable, enabled, wrapping up-counter; the same kind of counter as the fetch PC.
// Load has priority over increment; the count wraps modulo 2^W.
module counter_load12
  import program_loader_pkg::*;
#(
  parameter int W = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Packs an instruction/operand nibble stream into program bytes and writes them
// to program RAM at auto-incrementing addresses; busy holds off instruction fetch.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NIB_W  = DEF_NIB_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic                nib_valid,
  input  logic [NIB_W-1:0]    nib_data,
  output logic                nib_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2*NIB_W-1:0]  mem_wdata,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   byte_count
);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] byte_cnt;
  logic [NIB_W-1:0]  hi;
  logic [NIB_W-1:0]  lo;
  logic              start_ok;
  logic              take_hi;
  logic              take_lo;
  logic              in_write;

  assign start_ok = (state == ST_IDLE) && start;
  // Abort beats a simultaneous handshake, so the nibble is never captured.
  assign take_hi  = (state == ST_HI) && nib_valid && !abort;
  assign take_lo  = (state == ST_LO) && nib_valid && !abort;
  assign in_write = (state == ST_WRITE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (length == '0) ? ST_DONE : ST_HI;
      ST_HI:    if (abort) state_nx = ST_IDLE;
                else if (nib_valid) state_nx = ST_LO;
      ST_LO:    if (abort) state_nx = ST_IDLE;
                else if (nib_valid) state_nx = ST_WRITE;
      ST_WRITE: if (abort) state_nx = ST_IDLE;
                else state_nx = (remaining == ADDR_W'(1)) ? ST_DONE : ST_HI;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      byte_cnt  <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (start_ok) begin
        remaining <= length;
        byte_cnt  <= '0;
      end
      if (take_hi) hi <= nib_data;
      else if ((state == ST_HI) && abort) hi <= '0;
      if (take_lo) lo <= nib_data;
      if (in_write) begin
        remaining <= remaining - 1'b1;
        byte_cnt  <= byte_cnt + 1'b1;
      end
    end
  end

  counter_load12 #(.W(ADDR_W)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (start_ok),
    .load_val (base_addr),
    .en       (in_write),
    .q        (addr)
  );

  // Moore outputs; address and data are driven only while the strobe is high.
  assign nib_ready  = (state == ST_HI) || (state == ST_LO);
  assign mem_we     = in_write;
  assign mem_addr   = in_write ? addr : '0;
  assign mem_wdata  = in_write ? {hi, lo} : '0;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign byte_count = byte_cnt;

endmodule
